// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input side.
// Holds the writer FSM state encoding and the header field helpers.
// Header byte layout is {len[5:0], addr[1:0]}.
package router_pkg;

  localparam int NUM_PORTS  = 3;
  localparam int FIFO_DEPTH = 16;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  // Header field positions
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef enum logic [2:0] {
    DECODE     = 3'd0,
    WAIT_EMPTY = 3'd1,
    LOAD_DATA  = 3'd2,
    CHECK      = 3'd3,
    DROP       = 3'd4
  } state_t;

  function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

  // One-hot port select; the invalid address maps to no port at all.
  function automatic logic [NUM_PORTS-1:0] addr_onehot(input logic [1:0] addr);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (addr)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_pkt_writer_if.sv
// Source-side byte stream plus the FIFO-side control/status bundle.
// The writer uses the slave view; the environment uses the master view.
// All signals are single-clock, sampled on the rising edge of clock.
interface router_pkt_writer_if;
  import router_pkg::*;

  logic                 pkt_valid;
  logic [7:0]           data_in;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] read_enb;
  logic [NUM_PORTS-1:0] write_enb;
  logic [7:0]           fifo_data;
  logic                 lfd_state;
  logic                 busy;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  write_enb, fifo_data, lfd_state, busy, vld_out, soft_reset, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output write_enb, fifo_data, lfd_state, busy, vld_out, soft_reset, err
  );

endinterface

// File: rtl/router_sync_timer.sv
// Per-port idle timer: flushes a FIFO that holds data nobody reads.
// soft_reset is high for the one cycle the counter sits at TIMEOUT-1.
// Any read or an empty FIFO restarts the count from zero.
module router_sync_timer #(
  parameter int TIMEOUT = 30,
  parameter int TMR_W   = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q;

  assign soft_reset = (cnt_q == LAST);

  // Count idle cycles with data present; clear on read, empty or after the pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (!vld || rd || soft_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/router_pkt_writer.sv
// Input-side packet writer: decodes header address, writes header/payload/parity
// into one of three FIFOs with zero latency (FIFO captures on the accepting edge).
// busy stalls the source while the target FIFO is non-empty (header) or full (payload).
module router_pkt_writer
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30,
  parameter int TMR_W   = 5
) (
  input logic                 clock,
  input logic                 resetn,
  router_pkt_writer_if.slave  bus
);

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] par_q, par_d;
  logic       bad_q, bad_d;

  logic [1:0]           addr_in;
  logic [NUM_PORTS-1:0] oh_in;
  logic [NUM_PORTS-1:0] oh_q;
  logic                 sel_empty;
  logic                 sel_full;
  logic                 sel_srst;
  logic                 in_empty;
  state_t               abort_state;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] srst;

  assign addr_in     = hdr_addr(bus.data_in);
  assign oh_in       = addr_onehot(addr_in);
  assign oh_q        = addr_onehot(addr_q);
  assign in_empty    = |(bus.fifo_empty & oh_in);
  assign sel_empty   = |(bus.fifo_empty & oh_q);
  assign sel_full    = |(bus.fifo_full & oh_q);
  assign sel_srst    = |(srst & oh_q);
  // A flushed FIFO kills the packet; leftover bytes are skipped in DROP.
  assign abort_state = bus.pkt_valid ? DROP : DECODE;

  assign vld            = ~bus.fifo_empty;
  assign bus.vld_out    = vld;
  assign bus.soft_reset = srst;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_tmr
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .TMR_W   (TMR_W)
    ) u_tmr (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld[i]),
      .rd         (bus.read_enb[i]),
      .soft_reset (srst[i])
    );
  end

  // State, destination, held header and running parity registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE;
      addr_q  <= '0;
      hdr_q   <= '0;
      par_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic and the combinational FIFO write / source stall outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    hdr_d         = hdr_q;
    par_d         = par_q;
    bad_d         = bad_q;
    bus.write_enb = '0;
    bus.fifo_data = bus.data_in;
    bus.lfd_state = 1'b0;
    bus.busy      = 1'b0;
    bus.err       = 1'b0;

    case (state_q)
      DECODE: begin
        if (bus.pkt_valid) begin
          if (addr_in == ADDR_INVALID) begin
            state_d = DROP;
          end else begin
            addr_d = addr_in;
            hdr_d  = bus.data_in;
            par_d  = bus.data_in;
            bad_d  = 1'b0;
            if (in_empty) begin
              bus.write_enb = oh_in;
              bus.lfd_state = 1'b1;
              state_d       = LOAD_DATA;
            end else begin
              state_d = WAIT_EMPTY;
            end
          end
        end
      end

      WAIT_EMPTY: begin
        bus.busy = 1'b1;
        if (sel_srst) begin
          state_d = abort_state;
        end else if (sel_empty) begin
          bus.write_enb = oh_q;
          bus.fifo_data = hdr_q;
          bus.lfd_state = 1'b1;
          state_d       = LOAD_DATA;
        end
      end

      LOAD_DATA: begin
        bus.busy = sel_full;
        if (sel_srst) begin
          state_d = abort_state;
        end else if (!sel_full) begin
          bus.write_enb = oh_q;
          if (bus.pkt_valid) begin
            par_d = par_q ^ bus.data_in;
          end else begin
            // Byte with pkt_valid low is the parity byte: still stored, then compared.
            bad_d   = (par_q != bus.data_in);
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        bus.busy = 1'b1;
        bus.err  = bad_q;
        state_d  = sel_srst ? abort_state : DECODE;
      end

      DROP: begin
        if (!bus.pkt_valid) begin
          state_d = DECODE;
        end
      end

      default: begin
        state_d = DECODE;
      end
    endcase
  end

endmodule
